train_speed_ramp: RTL and testbench
===================================

TRAIN_SPEED_RAMP -- requirements
Module: train_speed_ramp

Interface
REQ-001 The block SHALL have parameter RAMP_TICKS, default 1000, meaning clocks per one-step change of cur_speed (legal range 2..65535).
REQ-002 The block SHALL have parameter PWM_DIV, default 100, meaning clocks per PWM slot (legal range 1..65535).
REQ-003 The block SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port speed_req  input  4  target speed, 0..15.
REQ-006 The block SHALL have port estop  input  1  emergency stop, level-sensitive.
REQ-007 The block SHALL have port en  output  1  PWM enable driving the downstream toggling output stage.
REQ-008 The block SHALL have port cur_speed  output  4  current ramped speed.
REQ-009 The block SHALL have port state  output  3  FSM state: IDLE=0, ACCEL=1, CRUISE=2, DECEL=3, ESTOP=4.
REQ-010 The block SHALL have port at_speed  output  1  high when cur_speed==speed_req and state!=ESTOP.

Function
REQ-011 ramp_cnt SHALL count 0..RAMP_TICKS-1 and wrap, free-running; the cycle where ramp_cnt==RAMP_TICKS-1 is a ramp tick.
REQ-012 slot_cnt SHALL count 0..PWM_DIV-1 and wrap; at each wrap pwm_cnt SHALL advance 0..14, wrapping 14->0 (15-slot period).
REQ-013 en SHALL be registered: en <= (pwm_cnt < cur_speed) evaluated on pre-edge register values, except forced 0 in ESTOP and in the cycle ESTOP is entered.
REQ-014 Duty boundaries: cur_speed=0 -> en constantly 0; cur_speed=15 -> en constantly 1; cur_speed=k -> en high k of 15 slots per period.
REQ-015 In ACCEL, cur_speed SHALL increment by 1 on each ramp tick; in DECEL, decrement by 1; otherwise hold.
REQ-016 cur_speed SHALL never overshoot speed_req and never wrap (no 15->0 or 0->15).
REQ-017 Transitions (non-ESTOP), evaluated every clock using post-update cur_speed: cur<req -> ACCEL; cur>req -> DECEL; cur==req!=0 -> CRUISE; cur==req==0 -> IDLE.
REQ-018 A speed_req change mid-ramp SHALL redirect the ramp on the next clock without resetting ramp_cnt.
REQ-019 estop=1 in any state SHALL, on the next edge, set state=ESTOP, cur_speed=0, en=0; estop has priority over speed_req and ramp tick in the same cycle.
REQ-020 ESTOP SHALL be left only when estop=0 and speed_req=0 in the same cycle, going to IDLE; estop=0 with speed_req!=0 SHALL hold ESTOP.
REQ-021 at_speed SHALL be combinational from registered cur_speed, state and input speed_req.

Reset
REQ-022 On a clock edge with rst=1: state=IDLE, cur_speed=0, en=0, ramp_cnt=0, slot_cnt=0, pwm_cnt=0; rst overrides estop.
REQ-023 rst asserted mid-ramp or in ESTOP SHALL abort immediately with the values of REQ-022; after release, behaviour restarts from IDLE per REQ-017.
REQ-024 Before the first reset, output values SHALL be undefined and no behaviour is required.

Verification (RAMP_TICKS=4, PWM_DIV=1)
REQ-025 rst 2 cycles, speed_req=0 -> state=0, cur_speed=0, en=0, at_speed=1 held for 50 cycles.
REQ-026 speed_req=3 after reset -> state=1, cur_speed 0->1->2->3 one step per 4 clocks, then state=2, at_speed=1, en high 3 of every 15 cycles.
REQ-027 speed_req=15 then settled -> en constantly 1; speed_req then 0 -> state=3, 15 ramp steps down, en duty falls, state=0 with en=0.
REQ-028 At cur_speed=6 ramping to 10, speed_req=2 -> next clock state=3, cur_speed decrements to 2 without exceeding 6, then state=2.
REQ-029 estop=1 at cur_speed=9 -> next edge state=4, cur_speed=0, en=0; estop=0 with speed_req=5 -> stays 4; speed_req=0 -> state=0.
REQ-030 rst=1 with estop=1 during ramp -> next edge state=0, cur_speed=0, en=0; rst=0, estop=0, speed_req=1 -> state=1, cur_speed=1 after 4 clocks.

Source files
------------

// File: rtl/train_speed_ramp.sv
// -----------------------------------------------------------------------------
// train_speed_ramp
//   Ramps a train's current speed toward a requested speed one step per
//   RAMP_TICKS clocks, and turns the current speed into a 15-slot PWM enable.
//   An emergency stop drops the speed and the enable to zero at once. The
//   block leaves the stop state only after the operator has set the request
//   back to zero.
//
// Ports
//   clk        in   clock, all logic on the rising edge
//   rst        in   synchronous active-high reset, overrides estop
//   speed_req  in   [3:0] target speed 0..15
//   estop      in   level-sensitive emergency stop
//   en         out  registered PWM enable for the output stage
//   cur_speed  out  [3:0] current ramped speed
//   state      out  [2:0] IDLE=0 ACCEL=1 CRUISE=2 DECEL=3 ESTOP=4
//   at_speed   out  cur_speed==speed_req and not in ESTOP (combinational)
// -----------------------------------------------------------------------------
module train_speed_ramp #(
   parameter int unsigned RAMP_TICKS = 1000,  // 2..65535
   parameter int unsigned PWM_DIV    = 100    // 1..65535
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] speed_req,
   input  logic       estop,
   output logic       en,
   output logic [3:0] cur_speed,
   output logic [2:0] state,
   output logic       at_speed
);

   localparam int unsigned RW = $clog2(RAMP_TICKS);
   localparam int unsigned SW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ACCEL  = 3'd1,
      CRUISE = 3'd2,
      DECEL  = 3'd3,
      ESTOP  = 3'd4
   } state_e;

   state_e        state_q, state_d;
   logic [3:0]    cur_q, cur_d;
   logic          en_q, en_d;
   logic [RW-1:0] ramp_cnt_q, ramp_cnt_d;
   logic [SW-1:0] slot_cnt_q, slot_cnt_d;
   logic [3:0]    pwm_cnt_q, pwm_cnt_d;
   logic          ramp_tick, slot_wrap;

   // Free-running timebases: ramp tick and PWM slot counters.
   always_comb begin
      ramp_tick  = (ramp_cnt_q == RW'(RAMP_TICKS - 1));
      ramp_cnt_d = ramp_tick ? '0 : ramp_cnt_q + RW'(1);
      slot_wrap  = (slot_cnt_q == SW'(PWM_DIV - 1));
      slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + SW'(1);
      pwm_cnt_d  = pwm_cnt_q;
      if (slot_wrap) begin
         pwm_cnt_d = (pwm_cnt_q == 4'd14) ? 4'd0 : pwm_cnt_q + 4'd1;
      end
   end

   // Speed ramp and state decision.
   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      // Pre-edge pwm/speed comparison gives k high slots out of 15.
      en_d    = (pwm_cnt_q < cur_q);

      if (estop) begin
         // Stop wins over any ramp tick or request change this cycle.
         state_d = ESTOP;
         cur_d   = 4'd0;
         en_d    = 1'b0;
      end else if (state_q == ESTOP) begin
         // Only a zero request re-arms the train, so it cannot lurch away.
         cur_d   = 4'd0;
         en_d    = 1'b0;
         state_d = (speed_req == 4'd0) ? IDLE : ESTOP;
      end else begin
         // The direction guards keep the speed from overshooting a request
         // that moved past cur_speed in the same cycle, and from wrapping.
         if (ramp_tick && (state_q == ACCEL) && (cur_q < speed_req)) begin
            cur_d = cur_q + 4'd1;
         end else if (ramp_tick && (state_q == DECEL) && (cur_q > speed_req)) begin
            cur_d = cur_q - 4'd1;
         end
         // Decide on the post-update speed so the state never lags a step.
         if (cur_d < speed_req) begin
            state_d = ACCEL;
         end else if (cur_d > speed_req) begin
            state_d = DECEL;
         end else if (cur_d == 4'd0) begin
            state_d = IDLE;
         end else begin
            state_d = CRUISE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cur_q      <= 4'd0;
         en_q       <= 1'b0;
         ramp_cnt_q <= '0;
         slot_cnt_q <= '0;
         pwm_cnt_q  <= 4'd0;
      end else begin
         state_q    <= state_d;
         cur_q      <= cur_d;
         en_q       <= en_d;
         ramp_cnt_q <= ramp_cnt_d;
         slot_cnt_q <= slot_cnt_d;
         pwm_cnt_q  <= pwm_cnt_d;
      end
   end

   assign en        = en_q;
   assign cur_speed = cur_q;
   assign state     = state_q;
   assign at_speed  = (cur_q == speed_req) && (state_q != ESTOP);

endmodule

// File: tb/tb_train_speed_ramp.sv
module tb_train_speed_ramp;

   localparam int RT = 4;
   localparam int PD = 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] speed_req = 4'd0;
   logic       estop = 1'b0;
   logic       en;
   logic [3:0] cur_speed;
   logic [2:0] state;
   logic       at_speed;

   int checks   = 0;
   int failures = 0;

   train_speed_ramp #(.RAMP_TICKS(RT), .PWM_DIV(PD)) dut (
      .clk(clk), .rst(rst), .speed_req(speed_req), .estop(estop),
      .en(en), .cur_speed(cur_speed), .state(state), .at_speed(at_speed)
   );

   always #5 clk = ~clk;

   // ---------------- scoreboard: reference model ----------------
   typedef struct {
      int st;
      int cur;
      int en;
      int at;
   } exp_t;

   exp_t sbq[$];

   initial begin : model
      int m_ramp, m_slot, m_pwm, m_cur, m_st, m_en, cyc;
      int n_cur, n_st, n_en, req;
      bit valid, tick;
      exp_t e, o;
      valid = 0; cyc = 0;
      m_ramp = 0; m_slot = 0; m_pwm = 0; m_cur = 0; m_st = 0; m_en = 0;
      forever begin
         @(posedge clk);
         cyc++;
         req = int'(speed_req);
         if (rst) begin
            m_ramp = 0; m_slot = 0; m_pwm = 0;
            m_cur = 0; m_st = 0; m_en = 0;
            valid = 1;
         end else begin
            tick  = (m_ramp == RT - 1);
            n_cur = m_cur;
            n_st  = m_st;
            n_en  = (m_pwm < m_cur) ? 1 : 0;
            if (estop) begin
               n_st = 4; n_cur = 0; n_en = 0;
            end else if (m_st == 4) begin
               n_cur = 0; n_en = 0;
               n_st  = (req == 0) ? 0 : 4;
            end else begin
               if (tick && m_st == 1 && m_cur < req) n_cur = m_cur + 1;
               if (tick && m_st == 3 && m_cur > req) n_cur = m_cur - 1;
               if (n_cur < req)      n_st = 1;
               else if (n_cur > req) n_st = 3;
               else if (n_cur == 0)  n_st = 0;
               else                  n_st = 2;
            end
            m_ramp = tick ? 0 : m_ramp + 1;
            if (m_slot == PD - 1) begin
               m_slot = 0;
               m_pwm  = (m_pwm == 14) ? 0 : m_pwm + 1;
            end else begin
               m_slot = m_slot + 1;
            end
            m_cur = n_cur; m_st = n_st; m_en = n_en;
         end
         e.st  = m_st;
         e.cur = m_cur;
         e.en  = m_en;
         e.at  = (m_cur == req && m_st != 4) ? 1 : 0;
         if (valid) sbq.push_back(e);
         #1;
         if (valid) begin
            o = sbq.pop_front();
            checks++;
            if (int'(state) !== o.st || int'(cur_speed) !== o.cur ||
                int'(en) !== o.en || int'(at_speed) !== o.at) begin
               failures++;
               $display("FAIL sb cyc=%0d got st=%0d cur=%0d en=%0d at=%0d exp st=%0d cur=%0d en=%0d at=%0d",
                        cyc, state, cur_speed, en, at_speed, o.st, o.cur, o.en, o.at);
            end
         end
      end
   end

   // Advance n clocks; returns 2 time units after the edge, safely away from it.
   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      int bad;
      rst = 1'b1; speed_req = 4'd0; estop = 1'b0;
      cyc(2);
      rst = 1'b0;
      checks++;
      if (state !== 3'd0 || cur_speed !== 4'd0 || en !== 1'b0 || at_speed !== 1'b1) begin
         failures++;
         $display("FAIL reset got st=%0d cur=%0d en=%0d at=%0d exp 0/0/0/1", state, cur_speed, en, at_speed);
      end
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         cyc(1);
         if (state !== 3'd0 || cur_speed !== 4'd0 || en !== 1'b0 || at_speed !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL idle_hold got bad_cycles=%0d exp 0", bad);
      end
   endtask

   task automatic test_accel;
      int last_chg, prev, n_int, bad_int, ones;
      bit done;
      speed_req = 4'd3;
      prev = 0; last_chg = -1; n_int = 0; bad_int = 0; done = 0;
      for (int i = 0; i < 100 && !done; i++) begin
         cyc(1);
         if (int'(cur_speed) != prev) begin
            if (last_chg >= 0) begin
               n_int++;
               if (i - last_chg != RT) bad_int++;
            end
            last_chg = i;
            prev = int'(cur_speed);
         end
         if (state == 3'd2) done = 1;
      end
      checks++;
      if (!done || cur_speed !== 4'd3 || at_speed !== 1'b1) begin
         failures++;
         $display("FAIL accel_cruise got st=%0d cur=%0d at=%0d exp 2/3/1", state, cur_speed, at_speed);
      end
      checks++;
      if (n_int != 2 || bad_int != 0) begin
         failures++;
         $display("FAIL accel_step got intervals=%0d bad=%0d exp 2/0", n_int, bad_int);
      end
      ones = 0;
      for (int i = 0; i < 15; i++) begin
         cyc(1);
         if (en === 1'b1) ones++;
      end
      checks++;
      if (ones != 3) begin
         failures++;
         $display("FAIL duty3 got high=%0d exp 3", ones);
      end
   endtask

   task automatic test_full_and_stop;
      int ones, steps, prev, bad;
      bit done;
      speed_req = 4'd15;
      done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         cyc(1);
         if (state == 3'd2 && cur_speed == 4'd15) done = 1;
      end
      ones = 0;
      for (int i = 0; i < 30; i++) begin
         cyc(1);
         if (en === 1'b1) ones++;
      end
      checks++;
      if (!done || ones != 30) begin
         failures++;
         $display("FAIL duty15 got reached=%0d high=%0d exp 1/30", done, ones);
      end
      speed_req = 4'd0;
      cyc(1);
      checks++;
      if (state !== 3'd3) begin
         failures++;
         $display("FAIL decel_enter got st=%0d exp 3", state);
      end
      steps = 0; prev = int'(cur_speed); bad = 0; done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         cyc(1);
         if (int'(cur_speed) != prev) begin
            if (int'(cur_speed) != prev - 1) bad++;
            steps++;
            prev = int'(cur_speed);
         end
         if (state == 3'd0) done = 1;
      end
      checks++;
      if (!done || steps != 15 || bad != 0) begin
         failures++;
         $display("FAIL decel_full got done=%0d steps=%0d bad=%0d exp 1/15/0", done, steps, bad);
      end
      cyc(1);
      checks++;
      if (en !== 1'b0 || cur_speed !== 4'd0) begin
         failures++;
         $display("FAIL idle_after got en=%0d cur=%0d exp 0/0", en, cur_speed);
      end
   endtask

   task automatic test_redirect;
      int maxc;
      bit done;
      speed_req = 4'd10;
      done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         cyc(1);
         if (cur_speed == 4'd6) done = 1;
      end
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL redirect_reach got cur=%0d exp 6", cur_speed);
      end
      speed_req = 4'd2;
      cyc(1);
      checks++;
      if (state !== 3'd3) begin
         failures++;
         $display("FAIL redirect_dir got st=%0d exp 3", state);
      end
      maxc = int'(cur_speed); done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         cyc(1);
         if (int'(cur_speed) > maxc) maxc = int'(cur_speed);
         if (state == 3'd2) done = 1;
      end
      checks++;
      if (!done || cur_speed !== 4'd2 || maxc > 6) begin
         failures++;
         $display("FAIL redirect_end got st=%0d cur=%0d max=%0d exp 2/2/<=6", state, cur_speed, maxc);
      end
   endtask

   task automatic test_estop;
      bit done;
      int bad;
      speed_req = 4'd12;
      done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         cyc(1);
         if (cur_speed == 4'd9) done = 1;
      end
      estop = 1'b1;
      cyc(1);
      checks++;
      if (!done || state !== 3'd4 || cur_speed !== 4'd0 || en !== 1'b0 || at_speed !== 1'b0) begin
         failures++;
         $display("FAIL estop_enter got st=%0d cur=%0d en=%0d at=%0d exp 4/0/0/0", state, cur_speed, en, at_speed);
      end
      estop = 1'b0; speed_req = 4'd5;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         if (state !== 3'd4 || en !== 1'b0 || cur_speed !== 4'd0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL estop_hold got bad_cycles=%0d exp 0", bad);
      end
      speed_req = 4'd0;
      cyc(1);
      checks++;
      if (state !== 3'd0 || at_speed !== 1'b1) begin
         failures++;
         $display("FAIL estop_exit got st=%0d at=%0d exp 0/1", state, at_speed);
      end
   endtask

   task automatic test_rst_estop;
      bit done;
      int n;
      speed_req = 4'd8;
      done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         cyc(1);
         if (cur_speed == 4'd3) done = 1;
      end
      rst = 1'b1; estop = 1'b1;
      cyc(1);
      checks++;
      if (state !== 3'd0 || cur_speed !== 4'd0 || en !== 1'b0) begin
         failures++;
         $display("FAIL rst_estop got st=%0d cur=%0d en=%0d exp 0/0/0", state, cur_speed, en);
      end
      rst = 1'b0; estop = 1'b0; speed_req = 4'd1;
      cyc(1);
      checks++;
      if (state !== 3'd1) begin
         failures++;
         $display("FAIL restart_accel got st=%0d exp 1", state);
      end
      n = 1; done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         if (cur_speed == 4'd1) done = 1;
         else begin
            cyc(1);
            n++;
         end
      end
      checks++;
      if (!done || n != RT) begin
         failures++;
         $display("FAIL restart_step got clocks=%0d exp %0d", n, RT);
      end
   endtask

   initial begin
      test_reset();
      test_accel();
      test_full_and_stop();
      test_redirect();
      test_estop();
      test_rst_estop();
      cyc(2);
      checks++;
      if (sbq.size() != 0) begin
         failures++;
         $display("FAIL sb_drain got pending=%0d exp 0", sbq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
